deal_sequencer: RTL and testbench

//   Hand-level dealing controller for the poker datapath. Pulls cards from the shuffled-deck source

---
 rtl/deal_sequencer_pkg.sv | 42 ++++
 rtl/deal_sequencer_if.sv | 17 +
 rtl/deal_seat_counter.sv | 59 +++++
 rtl/deal_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_deal_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deal_sequencer_pkg.sv
`default_nettype none
// =====================================================================
// deal_sequencer_pkg : card, street and table-size types for dealing
// Rev 1.0
// =====================================================================
package deal_sequencer_pkg;

  localparam int MAX_PLAYERS_DEF = 8;
  localparam int SEAT_W_DEF      = 3;
  localparam int HOLE_CARDS      = 2;
  localparam int FLOP_CARDS      = 3;

  // Rank 0 is reserved so an all-zero card reads as "no card dealt".
  typedef enum logic [3:0] {
    RANK_NONE = 4'd0,
    R_2 = 4'd2,  R_3 = 4'd3,  R_4 = 4'd4,  R_5 = 4'd5,  R_6 = 4'd6,
    R_7 = 4'd7,  R_8 = 4'd8,  R_9 = 4'd9,  R_T = 4'd10, R_J = 4'd11,
    R_Q = 4'd12, R_K = 4'd13, R_A = 4'd14
  } rank_t;

  typedef enum logic [1:0] {
    SUIT_C = 2'd0,
    SUIT_D = 2'd1,
    SUIT_H = 2'd2,
    SUIT_S = 2'd3
  } suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  typedef enum logic [2:0] {
    PREFLOP  = 3'd0,
    FLOP     = 3'd1,
    TURN     = 3'd2,
    RIVER    = 3'd3,
    SHOWDOWN = 3'd4
  } hand_state_t;

endpackage
`default_nettype wire

// File: rtl/deal_sequencer_if.sv
`default_nettype none
// =====================================================================
// deal_sequencer_if : valid/ready card stream from the shuffled deck
// Rev 1.0
// =====================================================================
interface deal_sequencer_if;
  import deal_sequencer_pkg::*;

  logic  card_valid;
  logic  card_ready;
  card_t card_in;

  modport master (output card_valid, output card_in, input card_ready);
  modport slave  (input card_valid, input card_in, output card_ready);

endinterface
`default_nettype wire

// File: rtl/deal_seat_counter.sv
`default_nettype none
// =====================================================================
// deal_seat_counter : hole-card index/pass counter with seat wrap
// Rev 1.0
// =====================================================================
module deal_seat_counter #(
  parameter int SEAT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [SEAT_W-1:0] n_i,
  input  logic [SEAT_W-1:0] dealer_i,
  output logic [SEAT_W-1:0] seat_o,
  output logic              pass_o,
  output logic              last_card_o
);

  logic [SEAT_W-1:0] k_q, k_d;
  logic              pass_q, pass_d;
  logic [SEAT_W:0]   sum;
  logic              last_k;

  // dealer+1+k is always below 2n, so one conditional subtract replaces a modulo.
  assign sum         = {1'b0, dealer_i} + {1'b0, k_q} + (SEAT_W+1)'(1);
  assign seat_o      = (sum >= {1'b0, n_i}) ? (sum[SEAT_W-1:0] - n_i) : sum[SEAT_W-1:0];
  assign last_k      = (k_q == (n_i - SEAT_W'(1)));
  assign pass_o      = pass_q;
  assign last_card_o = pass_q & last_k;

  always_comb begin
    k_d    = k_q;
    pass_d = pass_q;
    if (clr_i) begin
      k_d    = '0;
      pass_d = 1'b0;
    end else if (step_i) begin
      if (last_k) begin
        k_d    = '0;
        pass_d = ~pass_q;
      end else begin
        k_d = k_q + SEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q    <= '0;
      pass_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      pass_q <= pass_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/deal_sequencer.sv
`default_nettype none
// =====================================================================
// deal_sequencer : deals hole cards, then burn+flop/turn/river per hand
// Rev 1.0
// =====================================================================
module deal_sequencer
  import deal_sequencer_pkg::*;
#(
  parameter int MAX_PLAYERS = MAX_PLAYERS_DEF,
  parameter int SEAT_W      = SEAT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_hand_i,
  input  logic                advance_i,
  input  logic [SEAT_W-1:0]   player_count_i,
  input  logic [SEAT_W-1:0]   dealer_pos_i,
  deal_sequencer_if.slave     deck,
  output card_t               player_cards_o [HOLE_CARDS][MAX_PLAYERS],
  output card_t               flop_o [FLOP_CARDS],
  output card_t               turn_o,
  output card_t               river_o,
  output hand_state_t         curr_state_o,
  output logic                busy_o,
  output logic                street_done_o
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_DEAL_HOLE  = 4'd1,
    S_WAIT_FLOP  = 4'd2,
    S_BURN_F     = 4'd3,
    S_DEAL_FLOP  = 4'd4,
    S_WAIT_TURN  = 4'd5,
    S_BURN_T     = 4'd6,
    S_DEAL_TURN  = 4'd7,
    S_WAIT_RIVER = 4'd8,
    S_BURN_R     = 4'd9,
    S_DEAL_RIVER = 4'd10,
    S_SHOWDOWN   = 4'd11
  } seq_state_e;

  seq_state_e        state_q, state_d;
  logic [SEAT_W-1:0] n_q, n_d;
  logic [SEAT_W-1:0] dealer_q, dealer_d;
  card_t             player_cards_q [HOLE_CARDS][MAX_PLAYERS];
  card_t             player_cards_d [HOLE_CARDS][MAX_PLAYERS];
  card_t             flop_q [FLOP_CARDS];
  card_t             flop_d [FLOP_CARDS];
  card_t             turn_q, turn_d;
  card_t             river_q, river_d;
  logic [1:0]        flop_idx_q, flop_idx_d;
  hand_state_t       curr_state_q, curr_state_d;
  logic              busy_q, busy_d;
  logic              street_done_q, street_done_d;

  logic              card_ready;
  logic              accept;
  logic              advance_ok;
  logic              seat_step;
  logic [SEAT_W-1:0] seat;
  logic              seat_pass;
  logic              seat_last;

  // Ready depends on state only, never on card_valid.
  assign card_ready = state_q inside {S_DEAL_HOLE, S_BURN_F, S_DEAL_FLOP, S_BURN_T,
                                      S_DEAL_TURN, S_BURN_R, S_DEAL_RIVER};
  assign deck.card_ready = card_ready;
  assign accept          = deck.card_valid & card_ready;
  assign advance_ok      = advance_i & ~busy_q;

  deal_seat_counter #(
    .SEAT_W (SEAT_W)
  ) u_seat_counter (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (start_hand_i),
    .step_i      (seat_step),
    .n_i         (n_q),
    .dealer_i    (dealer_q),
    .seat_o      (seat),
    .pass_o      (seat_pass),
    .last_card_o (seat_last)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    dealer_d       = dealer_q;
    player_cards_d = player_cards_q;
    flop_d         = flop_q;
    turn_d         = turn_q;
    river_d        = river_q;
    flop_idx_d     = flop_idx_q;
    curr_state_d   = curr_state_q;
    busy_d         = busy_q & ~street_done_q;
    street_done_d  = 1'b0;
    seat_step      = 1'b0;

    // start_hand overrides everything, including a card handshaking this cycle.
    if (start_hand_i) begin
      state_d        = S_DEAL_HOLE;
      n_d            = (player_count_i < SEAT_W'(2)) ? SEAT_W'(2) : player_count_i;
      dealer_d       = dealer_pos_i;
      player_cards_d = '{default: '0};
      flop_d         = '{default: '0};
      turn_d         = '0;
      river_d        = '0;
      flop_idx_d     = '0;
      curr_state_d   = PREFLOP;
      busy_d         = 1'b1;
    end else begin
      case (state_q)
        S_DEAL_HOLE: if (accept) begin
          player_cards_d[seat_pass][seat] = deck.card_in;
          seat_step = 1'b1;
          if (seat_last) begin
            state_d       = S_WAIT_FLOP;
            curr_state_d  = PREFLOP;
            street_done_d = 1'b1;
          end
        end
        S_WAIT_FLOP: if (advance_ok) begin
          state_d = S_BURN_F;
          busy_d  = 1'b1;
        end
        S_BURN_F: if (accept) begin
          state_d    = S_DEAL_FLOP;
          flop_idx_d = '0;
        end
        S_DEAL_FLOP: if (accept) begin
          flop_d[flop_idx_q] = deck.card_in;
          flop_idx_d         = flop_idx_q + 2'd1;
          if (flop_idx_q == 2'(FLOP_CARDS - 1)) begin
            state_d       = S_WAIT_TURN;
            curr_state_d  = FLOP;
            street_done_d = 1'b1;
          end
        end
        S_WAIT_TURN: if (advance_ok) begin
          state_d = S_BURN_T;
          busy_d  = 1'b1;
        end
        S_BURN_T: if (accept) state_d = S_DEAL_TURN;
        S_DEAL_TURN: if (accept) begin
          turn_d        = deck.card_in;
          state_d       = S_WAIT_RIVER;
          curr_state_d  = TURN;
          street_done_d = 1'b1;
        end
        S_WAIT_RIVER: if (advance_ok) begin
          state_d = S_BURN_R;
          busy_d  = 1'b1;
        end
        S_BURN_R: if (accept) state_d = S_DEAL_RIVER;
        S_DEAL_RIVER: if (accept) begin
          river_d       = deck.card_in;
          state_d       = S_SHOWDOWN;
          curr_state_d  = RIVER;
          street_done_d = 1'b1;
        end
        // RIVER stays visible for its street_done cycle before SHOWDOWN lands.
        S_SHOWDOWN: curr_state_d = SHOWDOWN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= SEAT_W'(2);
      dealer_q       <= '0;
      player_cards_q <= '{default: '0};
      flop_q         <= '{default: '0};
      turn_q         <= '0;
      river_q        <= '0;
      flop_idx_q     <= '0;
      curr_state_q   <= PREFLOP;
      busy_q         <= 1'b0;
      street_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      dealer_q       <= dealer_d;
      player_cards_q <= player_cards_d;
      flop_q         <= flop_d;
      turn_q         <= turn_d;
      river_q        <= river_d;
      flop_idx_q     <= flop_idx_d;
      curr_state_q   <= curr_state_d;
      busy_q         <= busy_d;
      street_done_q  <= street_done_d;
    end
  end

  assign player_cards_o = player_cards_q;
  assign flop_o         = flop_q;
  assign turn_o         = turn_q;
  assign river_o        = river_q;
  assign curr_state_o   = curr_state_q;
  assign busy_o         = busy_q;
  assign street_done_o  = street_done_q;

endmodule
`default_nettype wire

// File: tb/tb_deal_sequencer.sv
`default_nettype none
// =====================================================================
// tb_deal_sequencer : directed hands checked against a card-index model
// Rev 1.0
// =====================================================================
module tb_deal_sequencer;
  import deal_sequencer_pkg::*;

  localparam int MP = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_hand = 1'b0;
  logic          advance = 1'b0;
  logic [SW-1:0] player_count = 3'd2;
  logic [SW-1:0] dealer_pos = 3'd0;
  card_t         player_cards [HOLE_CARDS][MP];
  card_t         flop [FLOP_CARDS];
  card_t         turn, river;
  hand_state_t   curr_state;
  logic          busy, street_done;

  deal_sequencer_if deck_if ();

  always #5 clk = ~clk;

  deal_sequencer #(.MAX_PLAYERS(MP), .SEAT_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_hand_i   (start_hand),
    .advance_i      (advance),
    .player_count_i (player_count),
    .dealer_pos_i   (dealer_pos),
    .deck           (deck_if),
    .player_cards_o (player_cards),
    .flop_o         (flop),
    .turn_o         (turn),
    .river_o        (river),
    .curr_state_o   (curr_state),
    .busy_o         (busy),
    .street_done_o  (street_done)
  );

  int checks = 0;
  int failures = 0;
  int sd_count = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cv(input card_t c);
    return {26'd0, c};
  endfunction

  function automatic logic [31:0] sv(input hand_state_t s);
    return {29'd0, s};
  endfunction

  function automatic card_t mk(input rank_t r, input suit_t s);
    card_t c;
    c.rank = r;
    c.suit = s;
    return c;
  endfunction

  // Model: the i-th card accepted in a hand has a fixed destination.
  int          m_n = 2, m_dealer = 0, m_cnt = 0, m_target = 0;
  bit          m_active = 0, m_ready = 0, m_busy = 0, m_sd = 0, m_acc = 0;
  hand_state_t m_state = PREFLOP;
  card_t       m_pc [2][MP];
  card_t       m_flop [3];
  card_t       m_turn, m_river;

  function automatic void model_clear();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < MP; s++) m_pc[p][s] = '0;
    for (int f = 0; f < 3; f++) m_flop[f] = '0;
    m_turn  = '0;
    m_river = '0;
  endfunction

  function automatic void place(input int i, input card_t c);
    int h;
    h = 2 * m_n;
    if (i < h) m_pc[i / m_n][(m_dealer + 1 + (i % m_n)) % m_n] = c;
    else if (i >= h + 1 && i <= h + 3) m_flop[i - h - 1] = c;
    else if (i == h + 5) m_turn = c;
    else if (i == h + 7) m_river = c;
  endfunction

  function automatic hand_state_t street_of(input int cnt);
    int h;
    h = 2 * m_n;
    if (cnt == h) return PREFLOP;
    if (cnt == h + 4) return FLOP;
    if (cnt == h + 6) return TURN;
    return RIVER;
  endfunction

  initial model_clear();

  always @(posedge clk) begin
    bit was_sd;
    m_acc = 1'b0;
    if (reset) begin
      model_clear();
      m_active = 0; m_cnt = 0; m_target = 0; m_sd = 0; m_state = PREFLOP;
    end else if (start_hand) begin
      model_clear();
      m_active = 1;
      m_n      = (player_count < 3'd2) ? 2 : int'(player_count);
      m_dealer = int'(dealer_pos);
      m_cnt    = 0;
      m_target = 2 * m_n;
      m_sd     = 0;
      m_state  = PREFLOP;
    end else begin
      was_sd = m_sd;
      m_sd   = 0;
      if (was_sd && m_state == RIVER) m_state = SHOWDOWN;
      if (m_ready && deck_if.card_valid) begin
        m_acc = 1'b1;
        place(m_cnt, deck_if.card_in);
        m_cnt++;
        if (m_cnt == m_target) begin
          m_sd    = 1;
          m_state = street_of(m_cnt);
        end
      end else if (advance && m_active && m_cnt == m_target && !was_sd && m_target < 2 * m_n + 8) begin
        m_target += (m_target == 2 * m_n) ? 4 : 2;
      end
    end
    m_ready = m_active && (m_cnt < m_target);
    m_busy  = m_ready || m_sd;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("card_ready", {31'd0, deck_if.card_ready}, {31'd0, m_ready});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("street_done", {31'd0, street_done}, {31'd0, m_sd});
      chk("curr_state", sv(curr_state), sv(m_state));
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < MP; s++)
          chk($sformatf("player_cards[%0d][%0d]", p, s), cv(player_cards[p][s]), cv(m_pc[p][s]));
      for (int f = 0; f < 3; f++) chk($sformatf("flop[%0d]", f), cv(flop[f]), cv(m_flop[f]));
      chk("turn", cv(turn), cv(m_turn));
      chk("river", cv(river), cv(m_river));
      if (street_done) sd_count++;
    end
  end

  // Stimulus tasks start and end on a falling edge.
  task automatic deal(input card_t c, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      deck_if.card_valid = 1'b0;
      @(negedge clk);
    end
    deck_if.card_valid = 1'b1;
    deck_if.card_in    = c;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_acc && t < 50);
    if (!m_acc) begin
      checks++;
      failures++;
      $display("FAIL deal_timeout actual=no_accept required=accept t=%0t", $time);
    end
    deck_if.card_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_start(input int pc, input int dp);
    player_count = SW'(pc);
    dealer_pos   = SW'(dp);
    start_hand   = 1'b1;
    @(negedge clk);
    start_hand   = 1'b0;
  endtask

  task automatic pulse_adv();
    wait_idle();
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    card_t c10 [10];
    card_t b2c;
    int    hits;

    deck_if.card_valid = 1'b0;
    deck_if.card_in    = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_state", sv(curr_state), sv(PREFLOP));
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, deck_if.card_ready}, 32'd0);
    chk("rst_flop0", cv(flop[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Heads-up, dealer seat 0: seat 1 gets the first card of each pass.
    sd_count = 0;
    pulse_start(2, 0);
    deal(mk(R_A, SUIT_S), 0);
    deal(mk(R_K, SUIT_H), 0);
    deal(mk(R_Q, SUIT_D), 0);
    deal(mk(R_J, SUIT_C), 0);
    repeat (3) @(negedge clk);
    chk("hu_p0s1", cv(player_cards[0][1]), 32'h3B);
    chk("hu_p0s0", cv(player_cards[0][0]), 32'h36);
    chk("hu_p1s1", cv(player_cards[1][1]), 32'h31);
    chk("hu_p1s0", cv(player_cards[1][0]), 32'h2C);
    chk("hu_state", sv(curr_state), sv(PREFLOP));
    chk("hu_sd_once", 32'(sd_count), 32'd1);
    chk("hu_ready_low", {31'd0, deck_if.card_ready}, 32'd0);

    // Five seats, dealer on the last seat: wrap to seat 0 first.
    pulse_start(5, 4);
    for (int i = 0; i < 10; i++) begin
      c10[i] = mk(rank_t'(2 + i), SUIT_H);
      deal(c10[i], 0);
    end
    wait_idle();
    chk("n5_first_seat0", cv(player_cards[0][0]), 32'h0A);
    chk("n5_tenth_p1s4", cv(player_cards[1][4]), 32'h2E);
    for (int p = 0; p < 2; p++)
      for (int s = 5; s < MP; s++)
        chk($sformatf("n5_empty[%0d][%0d]", p, s), cv(player_cards[p][s]), 32'd0);

    // Flop with the deck presenting a card only every other cycle.
    b2c = mk(R_2, SUIT_C);
    pulse_adv();
    deal(b2c, 1);
    deal(mk(R_T, SUIT_D), 1);
    deal(mk(R_7, SUIT_C), 1);
    chk("flop_partial_state", sv(curr_state), sv(PREFLOP));
    deal(mk(R_3, SUIT_H), 1);
    chk("flop_state", sv(curr_state), sv(FLOP));
    chk("flop_sd", {31'd0, street_done}, 32'd1);
    chk("flop0", cv(flop[0]), 32'h29);
    chk("flop1", cv(flop[1]), 32'h1C);
    chk("flop2", cv(flop[2]), 32'h0E);
    hits = 0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < MP; s++)
        if (player_cards[p][s] == b2c) hits++;
    for (int f = 0; f < 3; f++) if (flop[f] == b2c) hits++;
    chk("burn_absent", 32'(hits), 32'd0);

    pulse_adv();
    deal(mk(R_9, SUIT_S), 0);
    deal(mk(R_K, SUIT_S), 0);
    chk("turn_card", cv(turn), 32'h37);
    pulse_adv();
    deal(mk(R_8, SUIT_D), 0);
    deal(mk(R_5, SUIT_S), 0);
    chk("river_state", sv(curr_state), sv(RIVER));
    @(negedge clk);
    chk("showdown_state", sv(curr_state), sv(SHOWDOWN));

    // Advance and an offered card in SHOWDOWN must both be ignored.
    wait_idle();
    advance = 1'b1;
    deck_if.card_valid = 1'b1;
    deck_if.card_in    = mk(R_A, SUIT_C);
    repeat (3) begin
      @(negedge clk);
      chk("sd_ready_low", {31'd0, deck_if.card_ready}, 32'd0);
    end
    advance = 1'b0;
    deck_if.card_valid = 1'b0;
    chk("sd_hold_state", sv(curr_state), sv(SHOWDOWN));

    // Advance held high during the hole deal changes nothing.
    pulse_start(3, 1);
    advance = 1'b1;
    for (int i = 0; i < 6; i++) deal(mk(rank_t'(3 + i), SUIT_S), 0);
    advance = 1'b0;
    chk("n3_first_seat2", cv(player_cards[0][2]), 32'h0F);
    chk("n3_second_seat0", cv(player_cards[0][0]), 32'h13);
    pulse_adv();
    deal(mk(R_4, SUIT_C), 0);
    deal(mk(R_Q, SUIT_C), 0);

    // Restart mid-flop; the card offered alongside start_hand is dropped.
    player_count = 3'd3;
    dealer_pos   = 3'd1;
    start_hand   = 1'b1;
    deck_if.card_valid = 1'b1;
    deck_if.card_in    = mk(R_J, SUIT_H);
    @(negedge clk);
    start_hand = 1'b0;
    deck_if.card_valid = 1'b0;
    chk("abort_flop0", cv(flop[0]), 32'd0);
    chk("abort_hole", cv(player_cards[0][2]), 32'd0);
    chk("abort_state", sv(curr_state), sv(PREFLOP));
    chk("abort_ready", {31'd0, deck_if.card_ready}, 32'd1);
    for (int i = 0; i < 6; i++) deal(mk(rank_t'(8 + i), SUIT_D), 0);
    chk("restart_seat2", cv(player_cards[0][2]), 32'h21);

    // Reset while the turn card is being offered.
    pulse_adv();
    for (int i = 0; i < 4; i++) deal(mk(rank_t'(2 + i), SUIT_D), 0);
    pulse_adv();
    deal(mk(R_6, SUIT_H), 0);
    deck_if.card_valid = 1'b1;
    deck_if.card_in    = mk(R_A, SUIT_D);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_turn", cv(turn), 32'd0);
    chk("mid_rst_flop2", cv(flop[2]), 32'd0);
    chk("mid_rst_hole", cv(player_cards[1][2]), 32'd0);
    chk("mid_rst_state", sv(curr_state), sv(PREFLOP));
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, deck_if.card_ready}, 32'd0);
    chk("mid_rst_sd", {31'd0, street_done}, 32'd0);
    reset = 1'b0;
    deck_if.card_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
